// File: rtl/pipe_trace_buffer_pkg.sv
// Shared types and constants for the pipeline trace buffer:
// state encoding, opcode width, bubble IR value and entry-width helper.
package pipe_trace_pkg;

    localparam int OP_W = 6;
    localparam logic [31:0] NOP_IR = 32'h0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_POST  = 3'd2,
        ST_DONE  = 3'd3
    } trace_state_e;

    // Entry layout is {cycle, pc, ifid_ir, stage_op}
    function automatic int entry_width(input int cyc_w, input int data_w, input int stages);
        return cyc_w + 2 * data_w + OP_W * stages;
    endfunction

endpackage

// File: rtl/pipe_trace_buffer_if.sv
// Readout stream of the trace buffer: valid/ready handshake carrying one
// captured entry per transfer, with a last-entry marker.
interface pipe_trace_buffer_if #(
    parameter int ENTRY_W = 104
);
    logic               rd_valid;
    logic               rd_ready;
    logic [ENTRY_W-1:0] rd_data;
    logic               rd_last;

    modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
    modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/pipe_trace_buffer_ram.sv
// DEPTH x WIDTH trace storage: one synchronous write port and one
// synchronous read port whose output register holds until the next read.
module trace_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 104
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    // Only the read register is reset; the array itself keeps its contents
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/pipe_trace_buffer.sv
// Pipeline trace capture: circular history of PC/IR/latch opcodes, stopped a
// programmable window after a trigger opcode, then streamed out oldest-first.
// Optional macro TRACE_BUBBLE_SKIP_EN drops cycles whose IF/ID IR is a NOP.
module pipe_trace_buffer
    import pipe_trace_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int STAGES   = 4,
    parameter int DEPTH    = 16,
    parameter int CYC_W    = 16,
    parameter int POST_CNT = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      cap_en,
    input  logic                      arm,
    input  logic [OP_W-1:0]           trig_op,
    input  logic [DATA_W-1:0]         pc,
    input  logic [DATA_W-1:0]         ifid_ir,
    input  logic [OP_W*STAGES-1:0]    stage_op,
    output logic [2:0]                state,
    output logic                      triggered,
    output logic [$clog2(DEPTH):0]    fill_cnt,
    pipe_trace_buffer_if.master       rd
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = PTR_W + 1;
    localparam int E      = entry_width(CYC_W, DATA_W, STAGES);
    localparam logic [FILL_W-1:0] FULL      = FILL_W'(DEPTH);
    localparam logic [PTR_W-1:0]  POST_INIT = PTR_W'(POST_CNT);

    trace_state_e      state_q, state_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
    logic [PTR_W-1:0]  post_cnt_q, post_cnt_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic              triggered_q, triggered_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;

    logic              keep;
    logic              hit;
    logic              wr_en;
    logic              rd_en;
    logic [E-1:0]      wr_entry;

`ifdef TRACE_BUBBLE_SKIP_EN
    assign keep = (ifid_ir != DATA_W'(NOP_IR));
`else
    assign keep = 1'b1;
`endif

    assign wr_entry = {cyc_q, pc, ifid_ir, stage_op};

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < STAGES; i++) begin
            if (stage_op[i*OP_W +: OP_W] == trig_op) begin
                hit = 1'b1;
            end
        end
    end

    // Capture, trigger/post-window tracking and readout sequencing
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fill_cnt_d  = fill_cnt_q;
        post_cnt_d  = post_cnt_q;
        cyc_d       = cap_en ? cyc_q + CYC_W'(1) : cyc_q;
        triggered_d = triggered_q;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;
        wr_en       = 1'b0;
        rd_en       = 1'b0;

        if (arm && state_q != ST_DONE) begin
            state_d     = ST_ARMED;
            wr_ptr_d    = '0;
            fill_cnt_d  = '0;
            triggered_d = 1'b0;
        end else if ((state_q == ST_ARMED || state_q == ST_POST) && cap_en) begin
            wr_en = keep;
            if (keep) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (fill_cnt_q != FULL) begin
                    fill_cnt_d = fill_cnt_q + FILL_W'(1);
                end
            end
            if (state_q == ST_ARMED) begin
                if (hit) begin
                    triggered_d = 1'b1;
                    post_cnt_d  = POST_INIT;
                    state_d     = (POST_CNT == 0) ? ST_DONE : ST_POST;
                end
            end else if (keep) begin
                post_cnt_d = post_cnt_q - PTR_W'(1);
                if (post_cnt_q == PTR_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
        end else if (state_q == ST_DONE) begin
            // rd_ptr_q always names the entry to fetch next; fill counts the shown one
            if (!rd_valid_q) begin
                if (fill_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    rd_en      = 1'b1;
                    rd_ptr_d   = rd_ptr_q + PTR_W'(1);
                    rd_valid_d = 1'b1;
                    rd_last_d  = (fill_cnt_q == FILL_W'(1));
                end
            end else if (rd.rd_ready) begin
                fill_cnt_d = fill_cnt_q - FILL_W'(1);
                if (rd_last_q) begin
                    state_d    = ST_IDLE;
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                end else begin
                    rd_en     = 1'b1;
                    rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                    rd_last_d = (fill_cnt_q == FILL_W'(2));
                end
            end
        end

        if (state_q != ST_DONE && state_d == ST_DONE) begin
            rd_ptr_d = wr_ptr_d - fill_cnt_d[PTR_W-1:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fill_cnt_q  <= '0;
            post_cnt_q  <= '0;
            cyc_q       <= '0;
            triggered_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fill_cnt_q  <= fill_cnt_d;
            post_cnt_q  <= post_cnt_d;
            cyc_q       <= cyc_d;
            triggered_q <= triggered_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (E)
    ) u_ram (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_entry),
        .rd_en   (rd_en),
        .rd_addr (rd_ptr_q),
        .rd_data (rd.rd_data)
    );

    assign state       = state_q;
    assign triggered   = triggered_q;
    assign fill_cnt    = fill_cnt_q;
    assign rd.rd_valid = rd_valid_q;
    assign rd.rd_last  = rd_last_q;

endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed bench for pipe_trace_buffer: a default instance plus a CYC_W=4
// instance sharing stimulus so cycle-stamp wrap is visible in the buffer.
module tb_pipe_trace_buffer;
    import pipe_trace_pkg::*;

    localparam int E  = entry_width(16, 32, 4);
    localparam int E2 = entry_width(4, 32, 4);
`ifdef TRACE_BUBBLE_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        cap_en;
    logic        arm;
    logic [5:0]  trig_op;
    logic [31:0] pc;
    logic [31:0] ifid_ir;
    logic [23:0] stage_op;
    logic        rd_ready;
    logic [2:0]  state, state2;
    logic        triggered, triggered2;
    logic [4:0]  fill_cnt, fill_cnt2;

    int errors = 0;
    int checks = 0;

    pipe_trace_buffer_if #(.ENTRY_W(E))  rd_if ();
    pipe_trace_buffer_if #(.ENTRY_W(E2)) rd_if2 ();

    assign rd_if.rd_ready  = rd_ready;
    assign rd_if2.rd_ready = rd_ready;

    always #5 clock = ~clock;

    pipe_trace_buffer u_dut (
        .clock     (clock),
        .reset     (reset),
        .cap_en    (cap_en),
        .arm       (arm),
        .trig_op   (trig_op),
        .pc        (pc),
        .ifid_ir   (ifid_ir),
        .stage_op  (stage_op),
        .state     (state),
        .triggered (triggered),
        .fill_cnt  (fill_cnt),
        .rd        (rd_if)
    );

    pipe_trace_buffer #(.CYC_W(4)) u_dut_w4 (
        .clock     (clock),
        .reset     (reset),
        .cap_en    (cap_en),
        .arm       (arm),
        .trig_op   (trig_op),
        .pc        (pc),
        .ifid_ir   (ifid_ir),
        .stage_op  (stage_op),
        .state     (state2),
        .triggered (triggered2),
        .fill_cnt  (fill_cnt2),
        .rd        (rd_if2)
    );

    function automatic logic [31:0] pc_of(input int k);
        return 32'h1000 + 32'(4 * k);
    endfunction

    function automatic logic [31:0] ir_of(input int k, input bit bubble);
        if (bubble && (k % 2 == 1)) return 32'h0;
        return 32'hA000_0000 | 32'(k);
    endfunction

    function automatic logic [23:0] op_of(input int k, input int trig_k);
        logic [5:0] lane0;
        lane0 = 6'(k);
        return {6'h04, 6'h03, (k == trig_k) ? 6'h23 : 6'h02, lane0};
    endfunction

    function automatic logic [E-1:0] exp_entry(input int k, input int trig_k, input bit bubble);
        return {16'(k), pc_of(k), ir_of(k, bubble), op_of(k, trig_k)};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic armPulse();
        arm    = 1'b1;
        cap_en = 1'b0;
        tick();
        arm = 1'b0;
    endtask

    task automatic applyStimulus(input int k, input int trig_k, input bit bubble);
        cap_en   = 1'b1;
        pc       = pc_of(k);
        ifid_ir  = ir_of(k, bubble);
        stage_op = op_of(k, trig_k);
        tick();
        cap_en = 1'b0;
    endtask

    task automatic readOut(input int first_k, input int step, input int count,
                           input int trig_k, input bit bubble, input int stall_at);
        for (int i = 0; i < count; i++) begin
            int k;
            int w;
            k = first_k + i * step;
            w = 0;
            while (rd_if.rd_valid !== 1'b1 && w < 8) begin
                tick();
                w++;
            end
            checkOutput("rd_valid", rd_if.rd_valid, 1);
            checkOutput($sformatf("entry%0d", i), rd_if.rd_data, exp_entry(k, trig_k, bubble));
            checkOutput($sformatf("last%0d", i), rd_if.rd_last, (i == count - 1));
            checkOutput($sformatf("stamp_w4_%0d", i), rd_if2.rd_data[E2-1 -: 4], k % 16);
            if (i == stall_at) begin
                rd_ready = 1'b0;
                repeat (3) begin
                    tick();
                    checkOutput("stall_valid", rd_if.rd_valid, 1);
                    checkOutput("stall_data", rd_if.rd_data, exp_entry(k, trig_k, bubble));
                    checkOutput("stall_fill", fill_cnt, count - i);
                end
                rd_ready = 1'b1;
            end
            tick();
        end
        checkOutput("post_read_state", state, 0);
        checkOutput("post_read_valid", rd_if.rd_valid, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        cap_en   = 1'b0;
        arm      = 1'b0;
        trig_op  = 6'h23;
        pc       = '0;
        ifid_ir  = '0;
        stage_op = '0;
        rd_ready = 1'b1;
        tick();
        tick();
        checkOutput("rst_state", state, 0);
        checkOutput("rst_fill", fill_cnt, 0);
        checkOutput("rst_valid", rd_if.rd_valid, 0);
        checkOutput("rst_last", rd_if.rd_last, 0);
        checkOutput("rst_trig", triggered, 0);
        checkOutput("rst_data", rd_if.rd_data, 0);
        reset = 1'b0;

        $display("[TB] long capture with overwrite, trigger at stamp 12");
        armPulse();
        checkOutput("armed_state", state, 1);
        for (int k = 0; k <= 20; k++) begin
            applyStimulus(k, 12, 1'b0);
            if (k == 11) checkOutput("pre_trig", triggered, 0);
            if (k == 12) begin
                checkOutput("trig_flag", triggered, 1);
                checkOutput("trig_state", state, 2);
            end
            if (k == 19) checkOutput("post_state", state, 2);
        end
        checkOutput("done_state", state, 3);
        checkOutput("done_fill", fill_cnt, 16);
        checkOutput("done_valid_lat", rd_if.rd_valid, 0);
        tick();
        checkOutput("first_valid", rd_if.rd_valid, 1);
        readOut(5, 1, 16, 12, 1'b0, -1);

        $display("[TB] reset in post window");
        armPulse();
        for (int k = 0; k <= 5; k++) applyStimulus(k, 2, 1'b0);
        checkOutput("midpost_state", state, 2);
        reset = 1'b1;
        #1;
        checkOutput("async_state", state, 0);
        checkOutput("async_valid", rd_if.rd_valid, 0);
        checkOutput("async_trig", triggered, 0);
        checkOutput("async_fill", fill_cnt, 0);
        tick();
        reset = 1'b0;

        $display("[TB] early trigger, arm in DONE, readout stall");
        armPulse();
        for (int k = 0; k <= 10; k++) applyStimulus(k, 2, 1'b0);
        checkOutput("early_state", state, 3);
        checkOutput("early_fill", fill_cnt, 11);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        checkOutput("arm_in_done", state, 3);
        checkOutput("arm_done_fill", fill_cnt, 11);
        readOut(0, 1, 11, 2, 1'b0, 2);

        $display("[TB] bubble cycles on alternate IR");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        armPulse();
        for (int k = 0; k <= (SKIP ? 18 : 10); k++) applyStimulus(k, 2, 1'b1);
        checkOutput("bubble_state", state, 3);
        checkOutput("bubble_fill", fill_cnt, SKIP ? 10 : 11);
        readOut(0, SKIP ? 2 : 1, SKIP ? 10 : 11, 2, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_trace_buffer.md
Name: pipe_trace_buffer

Overview:
Synthesizable, parametrised trace capture block for the pipelined MIPS core. Each cycle it snapshots the PC, the IF/ID instruction register and the opcode of every pipeline latch into a circular buffer, and stops after a trigger opcode is seen plus a programmable post-trigger window. It then streams the captured history out oldest-first over a valid/ready port. It replaces the negedge display dump with on-chip history usable in silicon and in long regressions.

Parameters:
DATA_W, 32, width of PC and IR fields
STAGES, 4, number of pipeline latches whose 6-bit op is recorded (ID/EX, EX/MEM, MEM/WB, ...)
DEPTH, 16, buffer entries; power of two, >= 2
CYC_W, 16, cycle-stamp counter width
POST_CNT, 8, entries captured after the trigger entry; 0 <= POST_CNT < DEPTH

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high
cap_en  in  1  capture qualifier (pipeline advancing)
arm  in  1  one-cycle pulse: start a new capture
trig_op  in  6  opcode that fires the trigger
pc  in  DATA_W  IF/ID PC+4
ifid_ir  in  DATA_W  IF/ID instruction register
stage_op  in  6*STAGES  packed latch opcodes, stage 0 in bits [5:0]
state  out  3  0 IDLE, 1 ARMED, 2 POST, 3 DONE
triggered  out  1  sticky: trigger fired in current capture
fill_cnt  out  $clog2(DEPTH)+1  valid entries held
rd_valid  out  1  readout entry available
rd_ready  in  1  consumer accepts entry
rd_data  out  E  entry = {cycle, pc, ifid_ir, stage_op}; E = CYC_W+2*DATA_W+6*STAGES
rd_last  out  1  high with final entry of readout

Behaviour:
- Reset (async, any state): state IDLE, wr_ptr/rd_ptr/fill_cnt/post counter/cycle counter 0, triggered 0, rd_valid 0, rd_last 0, rd_data 0. Buffer contents are not cleared.
- Cycle counter: increments each clock with cap_en=1 in every state; wraps modulo 2^CYC_W. Entry stamp is the pre-increment value.
- IDLE: no writes. arm=1 -> ARMED; wr_ptr, fill_cnt, triggered cleared.
- ARMED: each cap_en cycle writes entry at wr_ptr; wr_ptr = (wr_ptr+1) mod DEPTH; fill_cnt saturates at DEPTH (oldest overwritten). If any stage_op lane == trig_op in a written cycle: that entry is stored, triggered=1, post counter=POST_CNT, next state POST (DONE if POST_CNT=0).
- POST: each cap_en cycle writes one entry and decrements the counter; the write that takes it 1->0 moves to DONE. Further trigger matches are ignored.
- Cycles with cap_en=0: no write, no counter change, no trigger evaluation.
- arm in ARMED or POST: restart (as from IDLE) in the same edge; that cycle's data is not written. arm in DONE: ignored.
- DONE: rd_ptr initialised to (wr_ptr - fill_cnt) mod DEPTH on entry; rd_valid=1 from the next cycle. rd_data is registered and held stable while rd_valid & !rd_ready. On rd_valid & rd_ready: advance rd_ptr, decrement fill_cnt. rd_last=1 when fill_cnt==1. Transfer with rd_last -> IDLE, rd_valid 0 next cycle. No capture in DONE.
- Latency: trigger cycle -> DONE after exactly POST_CNT further cap_en cycles; DONE -> first rd_valid 1 cycle.

Optional Feature:
TRACE_BUBBLE_SKIP_EN
- Defined: cycles with ifid_ir == 0 (NOP/bubble) are neither written nor counted against POST_CNT; trigger evaluation still applies to stage_op; the cycle counter still increments, so stamps show gaps.
- Undefined: every cap_en cycle is written.

Decomposition:
- Package pipe_trace_pkg: state encoding constants, NOP_IR constant (32'h0), opcode width 6, entry-width function of (CYC_W, DATA_W, STAGES).
- Sub-module trace_ram: DEPTH x E, one synchronous write port, one synchronous read port; no reset on storage.

Test Plan:
- Arm at cycle 0, cap_en=1 continuously, stage_op lane 1 = 6'h23 = trig_op at cycle 12 -> DONE after cycle 20; fill_cnt=16; 16 readout entries, stamps 5..20, rd_last on stamp 20, then state 0.
- Trigger at 3rd written entry (stamp 2) -> fill_cnt=11; readout stamps 0..10, no overwrite.
- During readout hold rd_ready=0 for 3 cycles -> rd_valid stays 1, rd_data unchanged, fill_cnt unchanged.
- CYC_W=4, run 20 cap_en cycles -> stamps wrap 15 -> 0 in the buffer.
- Assert reset mid-POST -> same cycle state 0, rd_valid 0, triggered 0, fill_cnt 0; a later arm runs a full capture normally.
- With TRACE_BUBBLE_SKIP_EN: ifid_ir=0 on alternating cycles -> only nonzero-IR entries stored, stamps step by 2.
